// File: rtl/map_diff_scanner.sv
// map_diff_scanner
//   Walks a GRID_W x GRID_H tile map in row-major order, compares each
//   cell's current object code (obj_in) against the code last drawn there
//   (held in an internal map RAM) and issues a draw command only for cells
//   that changed. A pass redraws every cell when it is requested with
//   force_full, and also when it is the first pass after reset, because the
//   map RAM is not cleared.
//
// Ports
//   clk         in   clock, all state on the rising edge
//   nrst        in   asynchronous active-low reset
//   start_frame in   pulse, request one scan pass (accepted only when idle)
//   force_full  in   sampled with an accepted start_frame, redraw every cell
//   obj_in      in   object code at (x,y), combinational from x/y
//   cmd_done    in   display sink finished the pending draw
//   x, y        out  current scan coordinate
//   draw_req    out  draw command pending
//   draw_code   out  code to draw at (x,y)
//   busy        out  pass in progress
//   frame_done  out  one-cycle pass-complete pulse
//   init_cycle  out  high until the first pass after reset completes
//   diff_count  out  cells drawn in the last completed pass
//
// Configuration
//   MAP_DIFF_STATS_EN  defined: diff_count reports the drawn-cell count of
//                      the last completed pass. Undefined: the counter is
//                      omitted and diff_count is tied to zero.
module map_diff_scanner #(
    parameter int GRID_W = 16,
    parameter int GRID_H = 12,
    parameter int CODE_W = 3,
    localparam int XW = ($clog2(GRID_W) > 1) ? $clog2(GRID_W) : 1,
    localparam int YW = ($clog2(GRID_H) > 1) ? $clog2(GRID_H) : 1,
    localparam int CW = $clog2(GRID_W * GRID_H + 1)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start_frame,
    input  logic              force_full,
    input  logic [CODE_W-1:0] obj_in,
    input  logic              cmd_done,
    output logic [XW-1:0]     x,
    output logic [YW-1:0]     y,
    output logic              draw_req,
    output logic [CODE_W-1:0] draw_code,
    output logic              busy,
    output logic              frame_done,
    output logic              init_cycle,
    output logic [CW-1:0]     diff_count
);

    localparam int NCELL = GRID_W * GRID_H;
    localparam int AW    = ($clog2(NCELL) > 1) ? $clog2(NCELL) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(GRID_H - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_REQ,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              full_q, full_d;
    logic              init_q, init_d;

    // Last drawn code per cell; deliberately not reset (first pass is full).
    logic [CODE_W-1:0] map_q [NCELL];
    logic [AW-1:0]     addr;
    logic              map_we;
    logic              mismatch;

    logic              last_x, last_cell;
    logic [XW-1:0]     x_adv;
    logic [YW-1:0]     y_adv;

    assign addr      = AW'(int'(y_q) * GRID_W + int'(x_q));
    assign mismatch  = full_q | (obj_in != map_q[addr]);

    // Row-major advance; the comparisons against the real last column/row
    // keep x/y inside the grid for non-power-of-2 sizes.
    assign last_x    = (x_q == X_LAST);
    assign last_cell = last_x && (y_q == Y_LAST);
    assign x_adv     = last_x ? '0 : x_q + XW'(1);
    assign y_adv     = last_x ? (last_cell ? '0 : y_q + YW'(1)) : y_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        code_d  = code_q;
        full_d  = full_q;
        init_d  = init_q;
        map_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_frame) begin
                    state_d = S_SCAN;
                    x_d     = '0;
                    y_d     = '0;
                    full_d  = force_full | init_q;
                end
            end
            S_SCAN: begin
                if (mismatch) begin
                    // Record the code now so the map already matches by the
                    // time the sink acknowledges the draw.
                    map_we  = 1'b1;
                    code_d  = obj_in;
                    state_d = S_REQ;
                end else begin
                    x_d     = x_adv;
                    y_d     = y_adv;
                    state_d = last_cell ? S_DONE : S_SCAN;
                end
            end
            S_REQ: begin
                if (cmd_done) begin
                    x_d     = x_adv;
                    y_d     = y_adv;
                    state_d = last_cell ? S_DONE : S_SCAN;
                end
            end
            S_DONE: begin
                init_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            code_q  <= '0;
            full_q  <= 1'b0;
            init_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            code_q  <= code_d;
            full_q  <= full_d;
            init_q  <= init_d;
        end
    end

    always_ff @(posedge clk) begin
        if (map_we) begin
            map_q[addr] <= obj_in;
        end
    end

`ifdef MAP_DIFF_STATS_EN
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] diff_q, diff_d;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        if (v >= CW'(NCELL)) begin
            return v;
        end
        return v + CW'(1);
    endfunction

    always_comb begin
        cnt_d  = cnt_q;
        diff_d = diff_q;
        if (state_q == S_IDLE && start_frame) begin
            cnt_d = '0;
        end else if (state_q == S_SCAN && mismatch) begin
            cnt_d = sat_inc(cnt_q);
        end
        if (state_q == S_DONE) begin
            diff_d = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q  <= '0;
            diff_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            diff_q <= diff_d;
        end
    end

    assign diff_count = diff_q;
`else
    assign diff_count = '0;
`endif

    assign x          = x_q;
    assign y          = y_q;
    assign draw_code  = code_q;
    assign draw_req   = (state_q == S_REQ);
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_DONE);
    assign init_cycle = init_q;

endmodule

// File: tb/tb_map_diff_scanner.sv
// Scoreboard bench for map_diff_scanner: a cell-list reference model
// predicts the draw commands of every pass; a monitor compares what the
// scanner actually issues. A randomized sink answers draw requests.
module tb_map_diff_scanner;

    parameter int GRID_W = 16;
    parameter int GRID_H = 12;
    parameter int CODE_W = 3;
    localparam int NCELL = GRID_W * GRID_H;
    localparam int XW = ($clog2(GRID_W) > 1) ? $clog2(GRID_W) : 1;
    localparam int YW = ($clog2(GRID_H) > 1) ? $clog2(GRID_H) : 1;
    localparam int CW = $clog2(GRID_W * GRID_H + 1);

    logic              clk = 1'b0;
    logic              nrst;
    logic              start_frame;
    logic              force_full;
    logic [CODE_W-1:0] obj_in;
    logic              cmd_done = 1'b0;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic              draw_req;
    logic [CODE_W-1:0] draw_code;
    logic              busy;
    logic              frame_done;
    logic              init_cycle;
    logic [CW-1:0]     diff_count;

    map_diff_scanner #(.GRID_W(GRID_W), .GRID_H(GRID_H), .CODE_W(CODE_W)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .start_frame(start_frame),
        .force_full (force_full),
        .obj_in     (obj_in),
        .cmd_done   (cmd_done),
        .x          (x),
        .y          (y),
        .draw_req   (draw_req),
        .draw_code  (draw_code),
        .busy       (busy),
        .frame_done (frame_done),
        .init_cycle (init_cycle),
        .diff_count (diff_count)
    );

    always #5 clk = ~clk;

    // The "world": object code per cell, row-major.
    logic [CODE_W-1:0] grid [NCELL];
    always_comb begin
        int idx;
        idx    = int'(y) * GRID_W + int'(x);
        obj_in = '0;
        if (idx < NCELL) obj_in = grid[idx];
    end

    typedef struct packed {
        logic [XW-1:0]     x;
        logic [YW-1:0]     y;
        logic [CODE_W-1:0] c;
    } draw_t;

    // Reference model: what the display currently shows per cell.
    logic [CODE_W-1:0] model_map [NCELL];
    bit                model_init;
    draw_t             exp_q[$];
    int                frame_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Predict one pass: every cell in row-major order that differs from
    // what is shown (or every cell, on a full redraw) yields one draw.
    function automatic void push_pass(input bit ff);
        bit full;
        int n;
        draw_t d;
        full = ff | model_init;
        n = 0;
        for (int c = 0; c < NCELL; c++) begin
            if (full || grid[c] !== model_map[c]) begin
                d.x = XW'(c % GRID_W);
                d.y = YW'(c / GRID_W);
                d.c = grid[c];
                exp_q.push_back(d);
                model_map[c] = grid[c];
                n++;
            end
        end
        frame_q.push_back(n);
        model_init = 1'b0;
    endfunction

    // Display sink: answers each draw after a random (or fixed) delay,
    // and emits stray cmd_done pulses while nothing is pending.
    int  fixed_dly = -1;
    int  max_dly   = 3;
    bit  noise     = 1'b1;
    int  dly       = -1;
    always @(negedge clk) begin
        if (!nrst) begin
            cmd_done = 1'b0;
            dly      = -1;
        end else if (!draw_req) begin
            dly      = -1;
            cmd_done = noise && ($urandom_range(0, 3) == 0);
        end else begin
            if (dly < 0) dly = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, max_dly));
            if (dly == 0) begin
                cmd_done = 1'b1;
            end else begin
                cmd_done = 1'b0;
                dly--;
            end
        end
    end

    // Monitor: pops the scoreboard on each new draw and on frame_done.
    logic  prev_req   = 1'b0;
    draw_t held;
    int    pass_draws = 0;
    bit    diff_pend  = 1'b0;
    int    diff_exp   = 0;
    always @(posedge clk) begin
        draw_t cur;
        draw_t e;
        int    n;
        #1;
        if (!nrst) begin
            prev_req   = 1'b0;
            diff_pend  = 1'b0;
            pass_draws = 0;
        end else begin
            if (diff_pend) begin
                chk("diff_count", diff_count, diff_exp);
                diff_pend = 1'b0;
            end
            cur.x = x;
            cur.y = y;
            cur.c = draw_code;
            if (draw_req && !prev_req) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_draw: got x=%0d y=%0d code=%0d, none expected", x, y, draw_code);
                end else begin
                    e = exp_q.pop_front();
                    chk("draw_xyc", cur, e);
                end
                held = cur;
                pass_draws++;
            end else if (draw_req) begin
                chk("draw_hold", cur, held);
            end
            if (frame_done) begin
                if (frame_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame_done: got frame_done=1, none expected");
                end else begin
                    n = frame_q.pop_front();
                    chk("frame_draws", pass_draws, n);
                    chk("wrap_xy", {x, y}, 0);
`ifdef MAP_DIFF_STATS_EN
                    diff_exp = n;
`else
                    diff_exp = 0;
`endif
                    diff_pend = 1'b1;
                end
                pass_draws = 0;
            end
            prev_req = draw_req;
        end
    end

    task automatic check_reset();
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_draw_req", draw_req, 0);
        chk("rst_draw_code", draw_code, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_init_cycle", init_cycle, 1);
        chk("rst_diff_count", diff_count, 0);
    endtask

    // Runs one pass from IDLE (called at a negedge). exp_lat >= 0 checks the
    // cycle distance from the start_frame cycle to frame_done. stray pulses
    // start_frame during the first draw request; a stray start is always
    // pulsed in the DONE cycle.
    task automatic run_pass(input bit ff, input int exp_lat, input bit stray);
        int lat;
        bit done;
        bit stray_done;
        push_pass(ff);
        start_frame = 1'b1;
        force_full  = ff;
        @(negedge clk);
        start_frame = 1'b0;
        force_full  = 1'($urandom);
        chk("busy_start", busy, 1);
        lat = 1;
        done = 1'b0;
        stray_done = 1'b0;
        while (!done && lat < 6000) begin
            if (frame_done) begin
                done = 1'b1;
            end else begin
                if (stray && !stray_done && draw_req) begin
                    start_frame = 1'b1;
                    stray_done  = 1'b1;
                end else begin
                    start_frame = 1'b0;
                end
                @(negedge clk);
                lat++;
            end
        end
        start_frame = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL pass_timeout: got no frame_done after %0d cycles, required one", lat);
        end else begin
            if (exp_lat >= 0) chk("frame_latency", lat, exp_lat);
            chk("busy_in_done", busy, 1);
            start_frame = 1'b1;
            @(negedge clk);
            start_frame = 1'b0;
            chk("busy_after_done", busy, 0);
        end
    endtask

    initial begin
        int c;
        int wait_cnt;
        nrst        = 1'b0;
        start_frame = 1'b0;
        force_full  = 1'b0;
        model_init  = 1'b1;
        for (int i = 0; i < NCELL; i++) grid[i] = CODE_W'($urandom);
        if (GRID_W > 7 && GRID_H > 4) begin
            grid[4 * GRID_W + 4] = '0;
            grid[4 * GRID_W + 7] = '0;
        end
        repeat (3) @(negedge clk);
        check_reset();
        nrst = 1'b1;
        @(negedge clk);

        // First pass after reset redraws everything.
        chk("init_before", init_cycle, 1);
        run_pass(1'b0, -1, 1'b0);
        chk("init_after", init_cycle, 0);

        // Unchanged map: no draws, SCAN cycles only.
        run_pass(1'b0, NCELL + 1, 1'b0);

        // Two changed cells.
        if (GRID_W > 7 && GRID_H > 4) begin
            grid[4 * GRID_W + 4] = CODE_W'(2);
            grid[4 * GRID_W + 7] = CODE_W'(3);
        end else begin
            grid[0] = grid[0] + CODE_W'(1);
            grid[NCELL - 1] = grid[NCELL - 1] + CODE_W'(1);
        end
        run_pass(1'b0, -1, 1'b0);

        // Slow sink with a start_frame pulsed mid-request.
        fixed_dly = 5;
        c = int'($urandom_range(0, NCELL - 1));
        grid[c] = grid[c] + CODE_W'(1);
        run_pass(1'b0, -1, 1'b1);
        fixed_dly = -1;

        // Forced full redraw of an unchanged map.
        run_pass(1'b1, -1, 1'b0);

        // Reset in the middle of a draw request.
        fixed_dly = 4;
        push_pass(1'b1);
        start_frame = 1'b1;
        force_full  = 1'b1;
        @(negedge clk);
        start_frame = 1'b0;
        force_full  = 1'b0;
        wait_cnt = 0;
        while (!draw_req && wait_cnt < 500) begin
            @(negedge clk);
            wait_cnt++;
        end
        chk("req_before_reset", draw_req, 1);
        nrst = 1'b0;
        #1;
        check_reset();
        exp_q.delete();
        frame_q.delete();
        model_init = 1'b1;
        @(negedge clk);
        nrst = 1'b1;
        fixed_dly = -1;
        @(negedge clk);

        // Post-reset pass is full again.
        run_pass(1'b0, -1, 1'b0);
        chk("init_after_reset_pass", init_cycle, 0);

        // Randomized passes.
        for (int p = 0; p < 6; p++) begin
            int nchg;
            nchg = int'($urandom_range(0, 6));
            for (int k = 0; k < nchg; k++) begin
                c = int'($urandom_range(0, NCELL - 1));
                grid[c] = CODE_W'($urandom);
            end
            max_dly = int'($urandom_range(0, 3));
            run_pass(($urandom_range(0, 7) == 0), -1, 1'($urandom));
        end

        repeat (3) @(negedge clk);
        chk("draws_left", exp_q.size(), 0);
        chk("frames_left", frame_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
